lcd_write_fsm: RTL and testbench
================================

Name: lcd_write_fsm

Overview:
- Consumer side of the LCD address controller: accepts `start`, screen address `addr` and the character byte read from message memory at the controller's current memory address.
- Once `start` drops, writes one character per iteration to the 16x2 character LCD over its 4-bit bus: Set-DDRAM-Address command, then a Write-Data byte.
- At the end of each iteration, pulses `change_addr` and `change_memory_addr` so the controller advances both addresses.
- Runs forever, refreshing the display, until reset or `start` re-asserts.

Parameters:
- SETUP_CYC, 2, cycles that `lcd_data`/`lcd_rs` are stable before `lcd_e` rises (40 ns at 50 MHz)
- E_HIGH_CYC, 12, cycles `lcd_e` is held high per nibble (>=230 ns)
- HOLD_CYC, 1, cycles data is held after `lcd_e` falls
- NIBBLE_GAP_CYC, 50, cycles between the upper-nibble hold and the lower-nibble setup (1 us)
- CMD_WAIT_CYC, 2000, cycles of wait after the lower nibble before the next byte (40 us)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- start  in  1  1 = init sequence owns the LCD; this block idles
- addr  in  7  DDRAM address for the current character (0-15, 64-79)
- char_data  in  8  ASCII byte from message memory at the controller's current memory address; valid combinationally
- change_addr  out  1  one-cycle pulse: advance screen address
- change_memory_addr  out  1  one-cycle pulse: advance memory address
- lcd_data  out  4  LCD D[7:4]
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0 (write only)

Behaviour:
- Reset (async): state IDLE, timing counter 0, byte register 0, phase = CMD.
  - All outputs 0: `lcd_data`, `lcd_e`, `lcd_rs`, `lcd_rw`, `change_addr`, `change_memory_addr`.
  - Reset asserted mid-operation forces `lcd_e` low immediately; no partial nibble completes.
- States: IDLE, LOAD_CMD, LOAD_DATA, HI_SETUP, HI_E, HI_HOLD, GAP, LO_SETUP, LO_E, LO_HOLD, WAIT, DONE.
- IDLE: outputs 0. Leaves to LOAD_CMD the first cycle `start` is sampled 0.
- LOAD_CMD (1 cycle):
  - byte <= {1'b1, addr}
  - `lcd_rs` <= 0, phase <= CMD
  - next state HI_SETUP
- LOAD_DATA (1 cycle):
  - byte <= char_data
  - `lcd_rs` <= 1, phase <= DATA
  - next state HI_SETUP
- Nibble states: each timed state lasts exactly its parameter's cycle count. A single 20-bit counter is cleared on every state entry.
  - `lcd_data` = byte[7:4] from HI_SETUP through GAP.
  - `lcd_data` = byte[3:0] from LO_SETUP through WAIT.
  - `lcd_e` = 1 only in HI_E and LO_E.
  - `lcd_rs` holds its loaded value through WAIT.
- Byte time = 2*(SETUP_CYC+E_HIGH_CYC+HOLD_CYC) + NIBBLE_GAP_CYC + CMD_WAIT_CYC (2080 cycles at defaults).
- WAIT exit:
  - phase CMD -> LOAD_DATA
  - phase DATA -> DONE
- DONE (1 cycle):
  - `change_addr` = `change_memory_addr` = 1, both registered outputs, high for exactly this cycle.
  - Next state: LOAD_CMD if `start` = 0, else IDLE.
  - LOAD_CMD therefore samples the already-updated `addr`/`char_data` one cycle after the pulse.
- Per-character period = 1 + byte + 1 + byte + 1 cycles (4163 at defaults). Pulses are strictly periodic with this spacing.
- `start` rising mid-character: ignored until DONE. The current character completes and its pulses are still issued; then IDLE.
- No wrap logic in this block: address sequencing (15->64, 79->0, memory 63->0) belongs entirely to the controller.
- Parameter value 0 is illegal. All parameters must be >= 1.

Test Plan:
(Params SETUP=1, E_HIGH=2, HOLD=1, GAP=3, WAIT=5 -> byte = 16 cycles, character period = 35 cycles. Bench includes a controller model and a 64-entry memory model.)
- Reset values: assert reset, hold `start`=1 -> all outputs 0; `lcd_e` never rises for 100 cycles.
- First command: release `start` with `addr`=0 -> `lcd_rs`=0; `lcd_e` pulses twice (2 cycles each); nibbles 0x8 then 0x0 sampled at the `lcd_e` falling edges.
- Data write: memory[0]=0x48 -> second byte has `lcd_rs`=1 and nibbles 0x4, 0x8. `change_addr` and `change_memory_addr` pulse together for 1 cycle exactly 35 cycles after leaving IDLE.
- Line change: run 16 characters -> 17th command byte is 0xC0 (`addr`=64). After 32 characters the command returns to 0x80. Pulse count equals character count.
- `start` re-asserted in the middle of LO_E -> nibble and WAIT complete, pulses issue once, then IDLE with all outputs 0.
- Reset during HI_E -> `lcd_e`=0 in the same cycle. After reset release and `start`=0, the sequence restarts with command 0x80.

Source files
------------

// File: rtl/lcd_write_if.sv
// Signal bundle between the LCD address controller and the LCD character writer.
// The controller side uses master; the writer FSM uses slave.
interface lcd_write_if;
  logic       start;
  logic [6:0] addr;
  logic [7:0] char_data;
  logic       change_addr;
  logic       change_memory_addr;
  logic [3:0] lcd_data;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;

  modport master (
    output start, addr, char_data,
    input  change_addr, change_memory_addr, lcd_data, lcd_e, lcd_rs, lcd_rw
  );

  modport slave (
    input  start, addr, char_data,
    output change_addr, change_memory_addr, lcd_data, lcd_e, lcd_rs, lcd_rw
  );
endinterface

// File: rtl/lcd_write_fsm.sv
// Writes one character per iteration to a 16x2 LCD over its 4-bit bus
// (Set-DDRAM-Address command, then data byte), then asks the controller to advance.
//
// state     | meaning
// IDLE      | init sequence owns the LCD, outputs quiet
// LOAD_CMD  | latch {1, addr} as a command byte
// LOAD_DATA | latch char_data as a data byte
// HI_SETUP  | upper nibble on the bus, E low
// HI_E      | upper nibble strobe
// HI_HOLD   | upper nibble held after E falls
// GAP       | pause between nibbles
// LO_SETUP  | lower nibble on the bus, E low
// LO_E      | lower nibble strobe
// LO_HOLD   | lower nibble held after E falls
// WAIT      | LCD execution time for the byte
// DONE      | pulse change_addr / change_memory_addr
module lcd_write_fsm #(
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int HOLD_CYC       = 1,
  parameter int NIBBLE_GAP_CYC = 50,
  parameter int CMD_WAIT_CYC   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  lcd_write_if.slave bus
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] LOAD_CMD  = 4'd1;
  localparam logic [3:0] LOAD_DATA = 4'd2;
  localparam logic [3:0] HI_SETUP  = 4'd3;
  localparam logic [3:0] HI_E      = 4'd4;
  localparam logic [3:0] HI_HOLD   = 4'd5;
  localparam logic [3:0] GAP       = 4'd6;
  localparam logic [3:0] LO_SETUP  = 4'd7;
  localparam logic [3:0] LO_E      = 4'd8;
  localparam logic [3:0] LO_HOLD   = 4'd9;
  localparam logic [3:0] WAIT      = 4'd10;
  localparam logic [3:0] DONE      = 4'd11;

  localparam logic [19:0] SETUP_LAST = 20'(SETUP_CYC - 1);
  localparam logic [19:0] E_LAST     = 20'(E_HIGH_CYC - 1);
  localparam logic [19:0] HOLD_LAST  = 20'(HOLD_CYC - 1);
  localparam logic [19:0] GAP_LAST   = 20'(NIBBLE_GAP_CYC - 1);
  localparam logic [19:0] WAIT_LAST  = 20'(CMD_WAIT_CYC - 1);

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  logic [19:0] cnt;
  logic [7:0]  byte_q;
  logic        rs_q;
  logic        phase_data;
  logic        pulse_q;
  logic        e_q;
  logic        hi_window;
  logic        lo_window;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!bus.start) state_nxt = LOAD_CMD;
      LOAD_CMD:  state_nxt = HI_SETUP;
      LOAD_DATA: state_nxt = HI_SETUP;
      HI_SETUP:  if (cnt == SETUP_LAST) state_nxt = HI_E;
      HI_E:      if (cnt == E_LAST)     state_nxt = HI_HOLD;
      HI_HOLD:   if (cnt == HOLD_LAST)  state_nxt = GAP;
      GAP:       if (cnt == GAP_LAST)   state_nxt = LO_SETUP;
      LO_SETUP:  if (cnt == SETUP_LAST) state_nxt = LO_E;
      LO_E:      if (cnt == E_LAST)     state_nxt = LO_HOLD;
      LO_HOLD:   if (cnt == HOLD_LAST)  state_nxt = WAIT;
      WAIT:      if (cnt == WAIT_LAST)  state_nxt = phase_data ? DONE : LOAD_DATA;
      // start is only honoured here so a character in flight always finishes.
      DONE:      state_nxt = bus.start ? IDLE : LOAD_CMD;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      byte_q     <= '0;
      rs_q       <= 1'b0;
      phase_data <= 1'b0;
      pulse_q    <= 1'b0;
      e_q        <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= (state_nxt != state || state == IDLE) ? '0 : cnt + 20'd1;
      pulse_q <= (state_nxt == DONE);
      // E is registered so the strobe to the panel is glitch-free.
      e_q     <= (state_nxt == HI_E) || (state_nxt == LO_E);
      if (state == LOAD_CMD) begin
        byte_q     <= {1'b1, bus.addr};
        rs_q       <= 1'b0;
        phase_data <= 1'b0;
      end
      if (state == LOAD_DATA) begin
        byte_q     <= bus.char_data;
        rs_q       <= 1'b1;
        phase_data <= 1'b1;
      end
    end
  end

  assign hi_window = (state >= HI_SETUP) && (state <= GAP);
  assign lo_window = (state >= LO_SETUP) && (state <= WAIT);

  assign bus.lcd_data           = hi_window ? byte_q[7:4] : (lo_window ? byte_q[3:0] : 4'h0);
  assign bus.lcd_e              = e_q;
  assign bus.lcd_rs             = rs_q && (state != IDLE);
  assign bus.lcd_rw             = 1'b0;
  assign bus.change_addr        = pulse_q;
  assign bus.change_memory_addr = pulse_q;

endmodule

// File: tb/tb_lcd_write_fsm.sv
// Bench for lcd_write_fsm: controller + memory model driving the writer, a
// character-timeline reference model, and literal checks of captured LCD bytes.
module tb_lcd_write_fsm;
  localparam int S = 1, E = 2, H = 1, G = 3, W = 5;
  localparam int BYTE_T = 2 * (S + E + H) + G + W;  // 16
  localparam int CHAR_T = 2 * BYTE_T + 3;           // 35
  localparam int LO0    = S + E + H + G;            // offset of lower nibble in a byte

  logic clk = 1'b0;
  logic reset = 1'b1;

  lcd_write_if bus();

  lcd_write_fsm #(
    .SETUP_CYC(S), .E_HIGH_CYC(E), .HOLD_CYC(H), .NIBBLE_GAP_CYC(G), .CMD_WAIT_CYC(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // controller + message memory
  logic [7:0] mem [64];
  int scr_i = 0;
  int mem_i = 0;
  assign bus.addr      = (scr_i < 16) ? 7'(scr_i) : 7'(scr_i + 48);
  assign bus.char_data = mem[mem_i];

  initial forever begin
    @(negedge clk);
    if (reset) begin
      scr_i = 0;
      mem_i = 0;
    end else begin
      if (bus.change_addr)        scr_i = (scr_i + 1) % 32;
      if (bus.change_memory_addr) mem_i = (mem_i + 1) % 64;
    end
  end

  // reference model: position m_k within the 35-cycle character, character index m_n
  bit m_run = 1'b0;
  int m_k = 0;
  int m_n = 0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_run = 1'b0; m_k = 0; m_n = 0;
    end else if (!m_run) begin
      if (!bus.start) begin m_run = 1'b1; m_k = 0; end
    end else if (m_k == CHAR_T - 1) begin
      m_n++;
      if (bus.start) m_run = 1'b0;
      else m_k = 0;
    end else begin
      m_k++;
    end
  end

  function automatic logic [7:0] exp_byte(input int n, input bit data);
    int s;
    s = n % 32;
    if (data) return mem[n % 64];
    return 8'h80 | 8'((s / 16) * 64 + (s % 16));
  endfunction

  int ck_o;
  bit ck_dt, ck_win, ck_e, ck_done;
  logic [7:0] ck_b;
  logic [3:0] ck_nib;

  always @(negedge clk) begin
    if (reset || !m_run) begin
      check("idle_out", 32'({bus.lcd_data, bus.lcd_e, bus.lcd_rs, bus.lcd_rw,
                             bus.change_addr, bus.change_memory_addr}), 32'd0);
    end else begin
      ck_dt   = (m_k > BYTE_T + 1);
      ck_o    = ck_dt ? m_k - (BYTE_T + 2) : m_k - 1;
      ck_win  = (ck_o >= 0) && (ck_o < BYTE_T);
      ck_done = (m_k == CHAR_T - 1);
      ck_e    = ck_win && ((ck_o >= S && ck_o < S + E) || (ck_o >= LO0 + S && ck_o < LO0 + S + E));
      check("strobe", 32'({bus.lcd_e, bus.lcd_rw, bus.change_addr, bus.change_memory_addr}),
            32'({ck_e, 1'b0, ck_done, ck_done}));
      if (ck_win) begin
        ck_b   = exp_byte(m_n, ck_dt);
        ck_nib = (ck_o < LO0) ? ck_b[7:4] : ck_b[3:0];
        check("nibble", 32'({bus.lcd_data, bus.lcd_rs}), 32'({ck_nib, ck_dt}));
      end
    end
  end

  // bus monitor: bytes reassembled from nibbles sampled as E falls
  logic [8:0] cap_q [$];
  bit prev_e = 1'b0;
  int nib_cnt = 0;
  logic [3:0] hi_nib;
  int pulses = 0;
  int e_in_reset = 0;
  time first_pulse_t = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_e = 1'b0;
      nib_cnt = 0;
      if (bus.lcd_e) e_in_reset++;
    end else begin
      if (prev_e && !bus.lcd_e) begin
        if (nib_cnt == 0) begin
          hi_nib = bus.lcd_data;
          nib_cnt = 1;
        end else begin
          cap_q.push_back({bus.lcd_rs, hi_nib, bus.lcd_data});
          nib_cnt = 0;
        end
      end
      prev_e = bus.lcd_e;
      if (bus.change_addr) begin
        pulses++;
        if (first_pulse_t == 0) first_pulse_t = $time;
      end
    end
  end

  time t0;
  int p0, c0, c1;
  bit ok;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h48;
    bus.start = 1'b1;
    reset = 1'b1;

    repeat (100) @(negedge clk);
    check("e_during_reset", 32'(e_in_reset), 32'd0);
    #2 reset = 1'b0;
    repeat (5) @(negedge clk);

    // 66 characters from a fresh start
    bus.start = 1'b0;
    t0 = $time;
    ok = 1'b0;
    for (int i = 0; i < 66 * CHAR_T + 100; i++) begin
      @(negedge clk);
      if (pulses >= 66) begin ok = 1'b1; break; end
    end
    check("run_timeout", 32'(ok), 32'd1);
    check("first_pulse_delay", 32'((first_pulse_t - t0) / 20), 32'd35);
    check("pulses_vs_chars", 32'(pulses), 32'(m_n));
    check("byte_count", 32'(cap_q.size()), 32'd132);
    check("first_cmd", 32'(cap_q[0]), 32'h080);
    check("first_data", 32'(cap_q[1]), 32'h148);
    check("line2_cmd", 32'(cap_q[32]), 32'h0C0);
    check("wrap_cmd", 32'(cap_q[64]), 32'h080);

    // start rises during LO_E of the data byte
    ok = 1'b0;
    for (int i = 0; i < 3 * CHAR_T; i++) begin
      @(negedge clk);
      if (m_run && m_k == BYTE_T + 2 + LO0 + S) begin ok = 1'b1; break; end
    end
    check("lo_e_timeout", 32'(ok), 32'd1);
    bus.start = 1'b1;
    p0 = pulses;
    c0 = cap_q.size();
    ok = 1'b0;
    for (int i = 0; i < 3 * CHAR_T; i++) begin
      @(negedge clk);
      if (!m_run) begin ok = 1'b1; break; end
    end
    check("stop_timeout", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    check("stop_pulses", 32'(pulses - p0), 32'd1);
    check("stop_bytes", 32'(cap_q.size() - c0), 32'd1);

    // reset during HI_E of a command byte
    bus.start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3 * CHAR_T; i++) begin
      @(negedge clk);
      if (m_run && m_k == 1 + S) begin ok = 1'b1; break; end
    end
    check("hi_e_timeout", 32'(ok), 32'd1);
    check("e_before_reset", 32'(bus.lcd_e), 32'd1);
    #2 reset = 1'b1;
    #1 check("e_at_reset", 32'(bus.lcd_e), 32'd0);
    repeat (3) @(negedge clk);
    c1 = cap_q.size();
    #2 reset = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2 * CHAR_T; i++) begin
      @(negedge clk);
      if (cap_q.size() > c1) begin ok = 1'b1; break; end
    end
    check("restart_timeout", 32'(ok), 32'd1);
    check("restart_cmd", 32'(cap_q[c1]), 32'h080);

    // random start activity, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.start) begin
        if ($urandom_range(0, 99) < 15) bus.start = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 2) bus.start = 1'b1;
      end
    end
    bus.start = 1'b1;
    repeat (2 * CHAR_T) @(negedge clk);
    check("final_idle", 32'(m_run), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
